// File: rtl/dbus_uart_master.sv
// UART-to-dbus bridge: 8N1 command frames ('W' addr data / 'R' addr) become single
// bus cycles on dbus, answered by 'K', two read-data bytes, or '?' on the TX line.
module dbus_uart_master #(
    parameter int DW      = 16,
    parameter int AW      = 16,
    parameter int CLK_DIV = 868,
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 65535
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          uart_rx,
    output logic          uart_tx,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    output logic          bus_we,
    input  logic [DW-1:0] bus_rdata,
    output logic          busy
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [LW-1:0] LAT_LAST  = LW'((RD_LAT > 0) ? RD_LAT - 1 : 0);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [3:0] {
        ST_CMD, ST_A_HI, ST_A_LO, ST_D_HI, ST_D_LO,
        ST_BUS_WR, ST_BUS_RD, ST_WAIT_RD, ST_RESP
    } cmd_state_e;

    // ---------------- RX path ----------------
    logic [1:0]    rx_sync_q, rx_sync_d;
    logic          rx_prev_q, rx_prev_d;
    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_valid_q, rx_valid_d;
    logic          rx_s;

    assign rx_s = rx_sync_q[1];

    // NOTE: every _d starts from its _q (or an explicit default) before any branch,
    // so no path through a combinational block can leave a variable unassigned.
    always_comb begin
        rx_sync_d  = {rx_sync_q[0], uart_rx};
        rx_prev_d  = rx_s;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                if (rx_prev_q && !rx_s) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_valid_d = rx_s;  // a low stop bit silently drops the byte
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // NOTE: clocked blocks use non-blocking assignments only, so every flop samples
    // the pre-edge value of every other flop regardless of evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_sync_q  <= rx_sync_d;
            rx_prev_q  <= rx_prev_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    // ---------------- Command FSM and TX path ----------------
    cmd_state_e    state_q, state_d;
    logic          is_wr_q, is_wr_d;
    logic [15:0]   addr_stage_q, addr_stage_d;
    logic [7:0]    data_hi_q, data_hi_d;
    logic [AW-1:0] bus_addr_q, bus_addr_d;
    logic [DW-1:0] bus_wdata_q, bus_wdata_d;
    logic          bus_we_q, bus_we_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [15:0]   resp_q, resp_d;
    logic [1:0]    resp_n_q, resp_n_d;
    logic          tx_active_q, tx_active_d;
    logic [9:0]    tx_shift_q, tx_shift_d;
    logic [3:0]    tx_bit_q, tx_bit_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic          uart_tx_q, uart_tx_d;
    logic          tx_done, tx_ready, tx_load;

    assign tx_done  = tx_active_q && (tx_bit_q == 4'd9) && (tx_cnt_q == BIT_LAST);
    // Loading on the final stop-bit cycle keeps queued response bytes back-to-back.
    assign tx_ready = !tx_active_q || tx_done;

    always_comb begin
        state_d      = state_q;
        is_wr_d      = is_wr_q;
        addr_stage_d = addr_stage_q;
        data_hi_d    = data_hi_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_we_d     = 1'b0;
        lat_d        = lat_q;
        tmo_d        = tmo_q;
        resp_d       = resp_q;
        resp_n_d     = resp_n_q;
        tx_active_d  = tx_active_q;
        tx_shift_d   = tx_shift_q;
        tx_bit_d     = tx_bit_q;
        tx_cnt_d     = tx_cnt_q;
        uart_tx_d    = uart_tx_q;
        tx_load      = 1'b0;

        if (tx_active_q) begin
            if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_d = '0;
                if (tx_bit_q == 4'd9) begin
                    tx_active_d = 1'b0;
                end else begin
                    tx_bit_d   = tx_bit_q + 1'b1;
                    tx_shift_d = {1'b1, tx_shift_q[9:1]};
                    uart_tx_d  = tx_shift_q[1];
                end
            end else begin
                tx_cnt_d = tx_cnt_q + 1'b1;
            end
        end

        unique case (state_q)
            ST_CMD: if (rx_valid_q) begin
                if (rx_shift_q == 8'h57) begin
                    is_wr_d = 1'b1;
                    state_d = ST_A_HI;
                end else if (rx_shift_q == 8'h52) begin
                    is_wr_d = 1'b0;
                    state_d = ST_A_HI;
                end else begin
                    resp_d   = {8'h3F, 8'h00};
                    resp_n_d = 2'd1;
                    state_d  = ST_RESP;
                end
            end
            ST_A_HI: if (rx_valid_q) begin
                addr_stage_d[15:8] = rx_shift_q;
                state_d            = ST_A_LO;
            end
            ST_A_LO: if (rx_valid_q) begin
                if (is_wr_q) begin
                    addr_stage_d[7:0] = rx_shift_q;
                    state_d           = ST_D_HI;
                end else begin
                    bus_addr_d = {addr_stage_q[15:8], rx_shift_q};
                    state_d    = ST_BUS_RD;
                end
            end
            ST_D_HI: if (rx_valid_q) begin
                data_hi_d = rx_shift_q;
                state_d   = ST_D_LO;
            end
            ST_D_LO: if (rx_valid_q) begin
                bus_addr_d  = addr_stage_q;
                bus_wdata_d = {data_hi_q, rx_shift_q};
                bus_we_d    = 1'b1;
                state_d     = ST_BUS_WR;
            end
            ST_BUS_WR: begin
                resp_d   = {8'h4B, 8'h00};
                resp_n_d = 2'd1;
                state_d  = ST_RESP;
            end
            ST_BUS_RD: begin
                lat_d = '0;
                if (RD_LAT == 0) begin
                    resp_d   = bus_rdata;
                    resp_n_d = 2'd2;
                    state_d  = ST_RESP;
                end else begin
                    state_d = ST_WAIT_RD;
                end
            end
            ST_WAIT_RD: begin
                if (lat_q == LAT_LAST) begin
                    resp_d   = bus_rdata;
                    resp_n_d = 2'd2;
                    state_d  = ST_RESP;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (tx_ready && resp_n_q != 2'd0) begin
                    tx_load  = 1'b1;
                    resp_d   = {resp_q[7:0], 8'h00};
                    resp_n_d = resp_n_q - 1'b1;
                end else if (resp_n_q == 2'd0 && !tx_active_q) begin
                    state_d = ST_CMD;
                end
            end
            default: state_d = ST_CMD;
        endcase

        // A stalled host cannot wedge the bridge half-way through a frame.
        if (state_q inside {ST_A_HI, ST_A_LO, ST_D_HI, ST_D_LO}) begin
            if (rx_valid_q) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
                tmo_d   = '0;
                state_d = ST_CMD;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
        end

        if (tx_load) begin
            tx_shift_d  = {1'b1, resp_q[15:8], 1'b0};
            tx_bit_d    = '0;
            tx_cnt_d    = '0;
            tx_active_d = 1'b1;
            uart_tx_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_CMD;
            is_wr_q      <= 1'b0;
            addr_stage_q <= '0;
            data_hi_q    <= '0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_we_q     <= 1'b0;
            lat_q        <= '0;
            tmo_q        <= '0;
            resp_q       <= '0;
            resp_n_q     <= '0;
            tx_active_q  <= 1'b0;
            tx_shift_q   <= '1;
            tx_bit_q     <= '0;
            tx_cnt_q     <= '0;
            uart_tx_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            is_wr_q      <= is_wr_d;
            addr_stage_q <= addr_stage_d;
            data_hi_q    <= data_hi_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_we_q     <= bus_we_d;
            lat_q        <= lat_d;
            tmo_q        <= tmo_d;
            resp_q       <= resp_d;
            resp_n_q     <= resp_n_d;
            tx_active_q  <= tx_active_d;
            tx_shift_q   <= tx_shift_d;
            tx_bit_q     <= tx_bit_d;
            tx_cnt_q     <= tx_cnt_d;
            uart_tx_q    <= uart_tx_d;
        end
    end

    assign uart_tx   = uart_tx_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_we    = bus_we_q;
    assign busy      = (state_q != ST_CMD);

endmodule

// File: tb/tb_dbus_uart_master.sv
// Bench for dbus_uart_master: drives host frames on uart_rx, decodes uart_tx, and
// scoreboards response bytes and bus writes against a memory/GPIO model.
module tb_dbus_uart_master;

    localparam int CLK_DIV = 4;
    localparam int RD_LAT  = 1;
    localparam int TIMEOUT = 100;
    localparam int NV      = 11;

    logic        clk = 1'b0;
    logic        rst;
    logic        uart_rx;
    logic        uart_tx;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_we;
    logic [15:0] bus_rdata;
    logic        busy;

    always #5 clk = ~clk;

    dbus_uart_master #(
        .DW(16), .AW(16), .CLK_DIV(CLK_DIV), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
        .bus_rdata(bus_rdata), .busy(busy)
    );

    int checks   = 0;
    int failures = 0;
    int we_count = 0;

    logic [7:0]  exp_tx[$];
    logic [31:0] exp_wr[$];
    logic [31:0] wr_e;
    logic [7:0]  tx_b;
    logic [7:0]  tx_e;

    // Bus-side model: RAM everywhere, gpio_in fixed at 0x1000, gpio_out at 0x1001.
    // Unwritten locations read back as the inverted address.
    logic [15:0] mem [0:65535];
    bit          written [0:65535];
    logic [15:0] gpio_out = 16'h0000;

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        if (a == 16'h1000) return 16'h001A;
        if (written[a]) return mem[a];
        return ~a;
    endfunction

    always @(posedge clk) begin
        if (bus_we === 1'b1) begin
            mem[bus_addr]     <= bus_wdata;
            written[bus_addr] <= 1'b1;
            if (bus_addr == 16'h1001) gpio_out <= bus_wdata;
        end
        bus_rdata <= mem_rd(bus_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Write scoreboard: every bus_we cycle must match the next queued write.
    always @(negedge clk) begin
        if (rst === 1'b1 && bus_we === 1'b1) begin
            we_count++;
            if (exp_wr.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%h:%h required=none", bus_addr, bus_wdata);
            end else begin
                wr_e = exp_wr.pop_front();
                check("write_addr", {16'h0, bus_addr}, {16'h0, wr_e[31:16]});
                check("write_data", {16'h0, bus_wdata}, {16'h0, wr_e[15:0]});
            end
        end
    end

    // TX decoder: samples each bit near its middle on falling clock edges.
    initial begin
        forever begin
            @(negedge uart_tx);
            repeat (CLK_DIV / 2) @(negedge clk);
            check("tx_start", {31'h0, uart_tx}, 32'h0);
            for (int i = 0; i < 8; i++) begin
                repeat (CLK_DIV) @(negedge clk);
                tx_b[i] = uart_tx;
            end
            repeat (CLK_DIV) @(negedge clk);
            check("tx_stop", {31'h0, uart_tx}, 32'h1);
            if (exp_tx.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_tx actual=%h required=none", tx_b);
            end else begin
                tx_e = exp_tx.pop_front();
                check("tx_byte", {24'h0, tx_b}, {24'h0, tx_e});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = frame[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        uart_rx = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        for (int n = 0; n < 4000; n++) begin
            if (exp_tx.size() == 0 && exp_wr.size() == 0 && busy === 1'b0) break;
            @(negedge clk);
        end
        check(name, 32'(exp_tx.size() * 256 + exp_wr.size() * 2) | {31'h0, busy}, 32'h0);
        repeat (3 * CLK_DIV) @(negedge clk);
    endtask

    typedef struct packed {
        logic [39:0] cmd;    // first byte in [39:32]
        logic [2:0]  ncmd;
        logic [15:0] rsp;    // first response byte in [15:8]
        logic [1:0]  nrsp;
        logic        wr;
        logic [15:0] waddr;
        logic [15:0] wdata;
    } vec_t;

    vec_t vecs [NV];
    vec_t v;

    initial begin
        vecs[0]  = '{40'h57_00_02_00_32, 3'd5, 16'h4B00, 2'd1, 1'b1, 16'h0002, 16'h0032};
        vecs[1]  = '{40'h52_00_02_00_00, 3'd3, 16'h0032, 2'd2, 1'b0, 16'h0000, 16'h0000};
        vecs[2]  = '{40'h52_10_00_00_00, 3'd3, 16'h001A, 2'd2, 1'b0, 16'h0000, 16'h0000};
        vecs[3]  = '{40'h57_10_01_00_3C, 3'd5, 16'h4B00, 2'd1, 1'b1, 16'h1001, 16'h003C};
        vecs[4]  = '{40'h57_20_01_12_34, 3'd5, 16'h4B00, 2'd1, 1'b1, 16'h2001, 16'h1234};
        vecs[5]  = '{40'h57_20_00_03_01, 3'd5, 16'h4B00, 2'd1, 1'b1, 16'h2000, 16'h0301};
        vecs[6]  = '{40'h52_20_01_00_00, 3'd3, 16'h1234, 2'd2, 1'b0, 16'h0000, 16'h0000};
        vecs[7]  = '{40'h41_00_00_00_00, 3'd1, 16'h3F00, 2'd1, 1'b0, 16'h0000, 16'h0000};
        vecs[8]  = '{40'h57_FF_FF_FF_FF, 3'd5, 16'h4B00, 2'd1, 1'b1, 16'hFFFF, 16'hFFFF};
        vecs[9]  = '{40'h52_FF_FF_00_00, 3'd3, 16'hFFFF, 2'd2, 1'b0, 16'h0000, 16'h0000};
        vecs[10] = '{40'h52_00_09_00_00, 3'd3, 16'hFFF6, 2'd2, 1'b0, 16'h0000, 16'h0000};

        uart_rx = 1'b1;
        rst     = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_uart_tx",   {31'h0, uart_tx},   32'h1);
        check("rst_bus_addr",  {16'h0, bus_addr},  32'h0);
        check("rst_bus_wdata", {16'h0, bus_wdata}, 32'h0);
        check("rst_bus_we",    {31'h0, bus_we},    32'h0);
        check("rst_busy",      {31'h0, busy},      32'h0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            exp_tx.push_back(v.rsp[15:8]);
            if (v.nrsp == 2'd2) exp_tx.push_back(v.rsp[7:0]);
            if (v.wr) exp_wr.push_back({v.waddr, v.wdata});
            for (int k = 0; k < int'(v.ncmd); k++) send_byte(v.cmd[39-8*k -: 8]);
            wait_idle($sformatf("vec%0d_drain", i));
        end
        check("gpio_out", {16'h0, gpio_out}, 32'h003C);

        // Bad stop bit: byte is dropped, so a following 0x41 is still a command.
        send_byte(8'h52, 1'b0);
        repeat (20) @(negedge clk);
        check("stopbit_busy", {31'h0, busy}, 32'h0);
        exp_tx.push_back(8'h3F);
        send_byte(8'h41);
        wait_idle("stopbit_drain");

        // One-clock low glitch on an idle line.
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_busy", {31'h0, busy}, 32'h0);
        exp_tx.push_back(8'h3F);
        send_byte(8'h00);
        wait_idle("glitch_drain");

        // Partial write frame abandoned by the host, then a read of the same address.
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h05);
        check("timeout_busy_mid", {31'h0, busy}, 32'h1);
        repeat (200) @(negedge clk);
        check("timeout_busy_after", {31'h0, busy}, 32'h0);
        exp_tx.push_back(8'hFF);
        exp_tx.push_back(8'hFA);
        send_byte(8'h52);
        send_byte(8'h00);
        send_byte(8'h05);
        wait_idle("timeout_drain");

        // Reset in the middle of the D_HI byte of a write to 0x0007.
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h07);
        uart_rx = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        uart_rx = 1'b1;
        repeat (CLK_DIV) @(negedge clk);
        uart_rx = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        rst     = 1'b0;
        uart_rx = 1'b1;
        @(negedge clk);
        check("mid_rst_uart_tx",   {31'h0, uart_tx},   32'h1);
        check("mid_rst_bus_addr",  {16'h0, bus_addr},  32'h0);
        check("mid_rst_bus_wdata", {16'h0, bus_wdata}, 32'h0);
        check("mid_rst_bus_we",    {31'h0, bus_we},    32'h0);
        check("mid_rst_busy",      {31'h0, busy},      32'h0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_busy", {31'h0, busy}, 32'h0);
        exp_tx.push_back(8'hFF);
        exp_tx.push_back(8'hF8);
        send_byte(8'h52);
        send_byte(8'h00);
        send_byte(8'h07);
        wait_idle("reset_drain");

        check("total_writes", 32'(we_count), 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
